// File: rtl/common_pkg.sv
// Shared types for the posit-to-fixed datapath: sign encoding, the fixed-point
// result bundle and a helper that sizes the signed scale field.
package common;

  typedef enum logic {
    SIGN_POS = 1'b0,
    SIGN_NEG = 1'b1
  } sign_t;

  // The result struct carries the block's default fixed-point format (8.8).
  localparam int FX_INT_DEF  = 8;
  localparam int FX_FRAC_DEF = 8;
  localparam int FX_W        = FX_INT_DEF + FX_FRAC_DEF;

  typedef struct packed {
    logic [FX_W-1:0] q;
    logic            sat;
    logic            nar;
  } fx_result_t;

  // Scale spans k*2^EN + e with |k| < WIDTH; two extra bits cover sign and e.
  function automatic int scale_width(input int width, input int en);
    return $clog2(width * (1 << en)) + 2;
  endfunction

endpackage

// File: rtl/fixed_shifter.sv
// Aligns a decoded posit onto the fixed-point grid: truncating shift of the
// magnitude, saturation to the signed range, then negation.
module fixed_shifter
  import common::*;
#(
  parameter int FX_INT  = 8,
  parameter int FX_FRAC = 8,
  parameter int SCALE_W = 6,
  parameter int MW      = 6
) (
  input  sign_t                     sign_i,
  input  logic signed [SCALE_W-1:0] scale_i,
  input  logic [MW-1:0]             mant_i,
  input  logic                      zero_i,
  input  logic                      nar_i,
  output fx_result_t                res_o
);

  localparam int FXW   = FX_INT + FX_FRAC;
  localparam int FW    = MW - 1;
  localparam int MAG_W = FXW + MW;

  logic [FXW-1:0] mag;
  int             shAmt;

  // With the hidden one set, value >= 2^scale, so saturation depends only on
  // the scale; below that bound the shifted magnitude always fits FXW-1 bits.
  always_comb begin
    res_o = '0;
    mag   = '0;
    shAmt = int'(scale_i) - FW + FX_FRAC;
    if (nar_i) begin
      res_o.nar = 1'b1;
    end else if (zero_i) begin
      res_o.q = '0;
    end else if (int'(scale_i) >= FX_INT - 1) begin
      res_o.sat = 1'b1;
      res_o.q   = (sign_i == SIGN_NEG) ? {1'b1, {(FXW-1){1'b0}}}
                                       : {1'b0, {(FXW-1){1'b1}}};
    end else begin
      if (shAmt >= 0) begin
        mag = FXW'(MAG_W'(mant_i) << shAmt);
      end else begin
        mag = FXW'(MAG_W'(mant_i) >> (-shAmt));
      end
      res_o.q = (sign_i == SIGN_NEG) ? (~mag + FXW'(1)) : mag;
    end
  end

endmodule

// File: rtl/format_decoder.sv
// Combinational posit field extraction: sign, special cases, the combined
// regime/exponent scale and the mantissa with its hidden one.
module format_decoder
  import common::*;
#(
  parameter int WIDTH   = 7,
  parameter int EN      = 1,
  parameter int SCALE_W = scale_width(WIDTH, EN),
  parameter int FW      = WIDTH - 1 - EN
) (
  input  logic [WIDTH-1:0]          p_i,
  output sign_t                     sign_o,
  output logic signed [SCALE_W-1:0] scale_o,
  output logic [FW:0]               mant_o,
  output logic                      zero_o,
  output logic                      nar_o
);

  localparam int BW = WIDTH - 1;

  logic [BW-1:0] body;
  logic [BW-1:0] rem;
  logic [EN-1:0] expBits;
  logic          lead;
  logic          runDone;
  int            run;
  int            k;

  // Negative posits are decoded from the two's complement of the whole word;
  // the regime is the run of bits equal to the first bit after the sign.
  always_comb begin
    body    = p_i[WIDTH-1] ? (~p_i[BW-1:0] + BW'(1)) : p_i[BW-1:0];
    lead    = body[BW-1];
    run     = 0;
    runDone = 1'b0;
    for (int i = BW - 1; i >= 0; i--) begin
      if (!runDone && (body[i] == lead)) begin
        run = run + 1;
      end else begin
        runDone = 1'b1;
      end
    end
    k       = lead ? (run - 1) : -run;
    rem     = (run >= BW) ? '0 : (body << (run + 1));
    expBits = rem[BW-1 -: EN];
    scale_o = SCALE_W'(k * (1 << EN) + int'(expBits));
    mant_o  = {1'b1, rem[FW-1:0]};
    sign_o  = p_i[WIDTH-1] ? SIGN_NEG : SIGN_POS;
    zero_o  = (p_i == '0);
    nar_o   = (p_i == {1'b1, {(WIDTH-1){1'b0}}});
  end

endmodule

// File: rtl/posit_to_fixed.sv
// Two-stage valid/ready pipeline converting a posit into signed fixed point:
// stage 1 holds the decoded fields, stage 2 holds the final q/sat/nar.
module posit_to_fixed
  import common::*;
#(
  parameter int WIDTH   = 7,
  parameter int EN      = 1,
  parameter int FX_INT  = 8,
  parameter int FX_FRAC = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           p,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FX_INT+FX_FRAC-1:0]  q,
  output logic                       sat,
  output logic                       nar
);

  localparam int SCALE_W = scale_width(WIDTH, EN);
  localparam int FW      = WIDTH - 1 - EN;
  localparam int MW      = FW + 1;

  sign_t                     decSign;
  logic signed [SCALE_W-1:0] decScale;
  logic [MW-1:0]             decMant;
  logic                      decZero;
  logic                      decNar;

  logic                      s1Valid_q, s1Valid_d;
  sign_t                     s1Sign_q, s1Sign_d;
  logic signed [SCALE_W-1:0] s1Scale_q, s1Scale_d;
  logic [MW-1:0]             s1Mant_q, s1Mant_d;
  logic                      s1Zero_q, s1Zero_d;
  logic                      s1Nar_q, s1Nar_d;

  logic                      s2Valid_q, s2Valid_d;
  fx_result_t                res_q, res_d;
  fx_result_t                shRes;

  logic                      s2Advance;

  format_decoder #(
    .WIDTH   (WIDTH),
    .EN      (EN),
    .SCALE_W (SCALE_W),
    .FW      (FW)
  ) u_decoder (
    .p_i     (p),
    .sign_o  (decSign),
    .scale_o (decScale),
    .mant_o  (decMant),
    .zero_o  (decZero),
    .nar_o   (decNar)
  );

  fixed_shifter #(
    .FX_INT  (FX_INT),
    .FX_FRAC (FX_FRAC),
    .SCALE_W (SCALE_W),
    .MW      (MW)
  ) u_shifter (
    .sign_i  (s1Sign_q),
    .scale_i (s1Scale_q),
    .mant_i  (s1Mant_q),
    .zero_i  (s1Zero_q),
    .nar_i   (s1Nar_q),
    .res_o   (shRes)
  );

  // Stage 2 moves when empty or drained; stage 1 refills in the same cycle it
  // hands off, so a full pipe streams without bubbles. Reset masks in_ready.
  assign s2Advance = ~s2Valid_q | out_ready;
  assign in_ready  = rst & (~s1Valid_q | s2Advance);

  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Sign_d  = s1Sign_q;
    s1Scale_d = s1Scale_q;
    s1Mant_d  = s1Mant_q;
    s1Zero_d  = s1Zero_q;
    s1Nar_d   = s1Nar_q;
    s2Valid_d = s2Valid_q;
    res_d     = res_q;
    if (in_ready) begin
      s1Valid_d = in_valid;
      if (in_valid) begin
        s1Sign_d  = decSign;
        s1Scale_d = decScale;
        s1Mant_d  = decMant;
        s1Zero_d  = decZero;
        s1Nar_d   = decNar;
      end
    end
    if (s2Advance) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        res_d = shRes;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1Valid_q <= 1'b0;
      s1Sign_q  <= SIGN_POS;
      s1Scale_q <= '0;
      s1Mant_q  <= '0;
      s1Zero_q  <= 1'b0;
      s1Nar_q   <= 1'b0;
      s2Valid_q <= 1'b0;
      res_q     <= '0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Sign_q  <= s1Sign_d;
      s1Scale_q <= s1Scale_d;
      s1Mant_q  <= s1Mant_d;
      s1Zero_q  <= s1Zero_d;
      s1Nar_q   <= s1Nar_d;
      s2Valid_q <= s2Valid_d;
      res_q     <= res_d;
    end
  end

  assign out_valid = s2Valid_q;
  assign q         = res_q.q;
  assign sat       = res_q.sat;
  assign nar       = res_q.nar;

endmodule

// File: tb/tb_posit_to_fixed.sv
// Scoreboard bench for posit_to_fixed: a real-arithmetic posit model predicts
// every accepted input, and results are checked in order as they leave.
module tb_posit_to_fixed;
  import common::*;

  localparam int WIDTH   = 7;
  localparam int EN      = 1;
  localparam int FX_INT  = 8;
  localparam int FX_FRAC = 8;
  localparam int FXW     = FX_INT + FX_FRAC;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] p;
  logic             out_valid;
  logic             out_ready;
  logic [FXW-1:0]   q;
  logic             sat;
  logic             nar;

  int         vecCount  = 0;
  int         missCount = 0;
  int         popCount  = 0;
  fx_result_t sbQ[$];

  logic [WIDTH-1:0] basicP [8] = '{7'b0100000, 7'b0110000, 7'b0011000, 7'b1100000,
                                   7'b0111111, 7'b1000001, 7'b1000000, 7'b0000001};
  logic [17:0] basicExp [8] = '{{16'h0100, 2'b00}, {16'h0400, 2'b00}, {16'h0080, 2'b00},
                                {16'hFF00, 2'b00}, {16'h7FFF, 2'b10}, {16'h8000, 2'b10},
                                {16'h0000, 2'b01}, {16'h0000, 2'b00}};

  posit_to_fixed #(
    .WIDTH   (WIDTH),
    .EN      (EN),
    .FX_INT  (FX_INT),
    .FX_FRAC (FX_FRAC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p         (p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .sat       (sat),
    .nar       (nar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Walks the posit bit by bit and evaluates the value in real arithmetic.
  function automatic fx_result_t model(input logic [WIDTH-1:0] pp);
    fx_result_t       r;
    logic [WIDTH-1:0] x;
    logic             first;
    int               i, run, k, e;
    real              f, w, scaled;
    int               mag;
    r = '0;
    if (pp == '0) return r;
    if (pp == {1'b1, {(WIDTH-1){1'b0}}}) begin
      r.nar = 1'b1;
      return r;
    end
    x = pp[WIDTH-1] ? -pp : pp;
    i = WIDTH - 2;
    first = x[i];
    run = 0;
    while (i >= 0 && x[i] == first) begin
      run++;
      i--;
    end
    k = first ? run - 1 : -run;
    i--;
    e = 0;
    for (int j = 0; j < EN; j++) begin
      e = e * 2 + ((i >= 0) ? int'(x[i]) : 0);
      i--;
    end
    f = 1.0;
    w = 0.5;
    while (i >= 0) begin
      if (x[i]) f = f + w;
      w = w / 2.0;
      i--;
    end
    scaled = f * (2.0 ** (k * (2 ** EN) + e + FX_FRAC));
    if (scaled >= 2.0 ** (FX_INT - 1 + FX_FRAC)) begin
      r.sat = 1'b1;
      r.q   = pp[WIDTH-1] ? {1'b1, {(FXW-1){1'b0}}} : {1'b0, {(FXW-1){1'b1}}};
    end else begin
      mag = $rtoi(scaled);
      r.q = pp[WIDTH-1] ? FXW'(-mag) : FXW'(mag);
    end
    return r;
  endfunction

  // Mid-cycle sampling: a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    fx_result_t expR;
    if (out_valid && out_ready) begin
      if (sbQ.size() == 0) begin
        checkOutput("spurious", 64'(out_valid), 64'(0));
      end else begin
        expR = sbQ.pop_front();
        checkOutput("result", 64'({q, sat, nar}), 64'(expR));
        popCount++;
      end
    end
    if (in_valid && in_ready) sbQ.push_back(model(p));
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] pp, output int waited);
    bit acc;
    in_valid = 1'b1;
    p        = pp;
    acc      = 1'b0;
    waited   = 0;
    while (!acc && waited < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) checkOutput("accept_timeout", 64'(in_ready), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int g = 0;
    while (sbQ.size() != 0 && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    checkOutput("drain", 64'(sbQ.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int               waited;
    int               base;
    int               accepts;
    int               idx;
    bit               acc;
    logic [17:0]      held;
    logic [WIDTH-1:0] bpVals [6] = '{7'b0100000, 7'b0101000, 7'b1011000,
                                     7'b0010101, 7'b1110011, 7'b0111000};

    rst = 1'b1; in_valid = 1'b0; p = '0; out_ready = 1'b1;
    #1 rst = 1'b0;
    #2;
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_in_ready", 64'(in_ready), 64'(0));
    checkOutput("rst_result", 64'({q, sat, nar}), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("rdy_after_rst", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    $display("[TB] basic and special values");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(basicP[i], waited);
      checkOutput("lat_early", 64'(out_valid), 64'(0));
      @(posedge clk);
      #1;
      checkOutput("lat_valid", 64'(out_valid), 64'(1));
      checkOutput("basic", 64'({q, sat, nar}), 64'(basicExp[i]));
      @(posedge clk);
      #1;
    end
    waitDrain();

    $display("[TB] streaming");
    base = popCount;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(WIDTH'($urandom), waited);
      checkOutput("stream_rdy", 64'(waited), 64'(1));
    end
    @(posedge clk);
    #1;
    checkOutput("stream_cnt15", 64'(popCount - base), 64'(15));
    @(posedge clk);
    #1;
    checkOutput("stream_cnt16", 64'(popCount - base), 64'(16));
    waitDrain();

    $display("[TB] backpressure");
    out_ready = 1'b0;
    in_valid  = 1'b1;
    idx       = 0;
    p         = bpVals[idx];
    accepts   = 0;
    held      = '0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      acc = in_ready;
      if (cyc == 2) held = {q, sat, nar};
      if (cyc >= 3) begin
        checkOutput("bp_hold", 64'({q, sat, nar}), 64'(held));
        checkOutput("bp_valid", 64'(out_valid), 64'(1));
      end
      @(posedge clk);
      #1;
      if (acc) begin
        accepts++;
        idx++;
        p = bpVals[idx];
      end
    end
    checkOutput("bp_accepts", 64'(accepts), 64'(2));
    checkOutput("bp_in_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    for (int i = idx; i < 6; i++) applyStimulus(bpVals[i], waited);
    waitDrain();

    $display("[TB] mid-operation reset");
    out_ready = 1'b0;
    applyStimulus(7'b0101010, waited);
    applyStimulus(7'b1010101, waited);
    rst = 1'b0;
    #1;
    checkOutput("mrst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("mrst_in_ready", 64'(in_ready), 64'(0));
    checkOutput("mrst_result", 64'({q, sat, nar}), 64'(0));
    sbQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("mrst_stale", 64'(out_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    applyStimulus(7'b0110000, waited);
    @(posedge clk);
    #1;
    checkOutput("mrst_next", 64'({q, sat, nar}), 64'({16'h0400, 2'b00}));
    waitDrain();

    $display("[TB] random traffic");
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 2) != 0);
        p        = WIDTH'($urandom);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
